sp_psum_accumulator: RTL and testbench



---
 rtl/sp_tc_pkg.sv | 15 +
 rtl/sp_psum_accumulator_if.sv | 37 +++
 rtl/sp_valid_delay.sv | 32 +++
 rtl/sp_psum_accumulator.sv | 118 +++++++++++
 tb/tb_sp_psum_accumulator.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_tc_pkg.sv
// Shared types and constants for the sparse tensor-core partial-sum path.
// Used by sp_psum_accumulator, its interface and sp_valid_delay.
package sp_tc_pkg;

  localparam int PSUM_W = 16;
  localparam int LANES  = 4;
  localparam int OUT_W  = LANES * PSUM_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } psum_state_t;

endpackage

// File: rtl/sp_psum_accumulator_if.sv
// Bundle between the partial-sum accumulator, the threadgroup and the tile consumer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge, and never
// waits for ready before raising valid. The consumer may change ready freely.
// step_valid/step_ready carry one accumulation step, out_valid/out_ready one tile.
interface sp_psum_accumulator_if;
  import sp_tc_pkg::*;

  logic                     step_valid;
  logic                     step_ready;
  logic signed [PSUM_W-1:0] result0;
  logic signed [PSUM_W-1:0] result1;
  logic signed [PSUM_W-1:0] result2;
  logic signed [PSUM_W-1:0] result3;
  logic signed [PSUM_W-1:0] partial_sum0;
  logic signed [PSUM_W-1:0] partial_sum1;
  logic signed [PSUM_W-1:0] partial_sum2;
  logic signed [PSUM_W-1:0] partial_sum3;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;

  // Threadgroup / consumer side.
  modport master (
    output step_valid, result0, result1, result2, result3, out_ready,
    input  step_ready, partial_sum0, partial_sum1, partial_sum2, partial_sum3,
           out_valid, out_data
  );

  // Accumulator side.
  modport slave (
    input  step_valid, result0, result1, result2, result3, out_ready,
    output step_ready, partial_sum0, partial_sum1, partial_sum2, partial_sum3,
           out_valid, out_data
  );

endinterface

// File: rtl/sp_valid_delay.sv
// DEPTH-deep valid shift register. taps shows every in-flight token, strobe
// fires DEPTH cycles after in_valid was sampled. Reusable for aligning any
// threadgroup-side signal with the FEDP pipeline.
module sp_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [DEPTH-1:0] taps,
  output logic             strobe
);

  generate
    if (DEPTH == 1) begin : g_one
      // Single-stage delay.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) taps <= '0;
        else     taps <= in_valid;
      end
    end else begin : g_multi
      // Shift toward the MSB; the MSB is the capture point.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) taps <= '0;
        else     taps <= {taps[DEPTH-2:0], in_valid};
      end
    end
  endgenerate

  assign strobe = taps[DEPTH-1];

endmodule

// File: rtl/sp_psum_accumulator.sv
// Partial-sum accumulator for the sparse threadgroup (4 FEDPs).
// Holds four PSUM_W lanes across K_STEPS steps of one output tile, feeds them to
// the FEDPs as partial_sum0..3, captures result0..3 FEDP_LAT cycles after each
// issued step, and offers the finished tile on out_valid/out_ready.
// Only one step is in flight at a time because each step consumes the previous sum.
// Optional build macro PSUM_BIAS_INIT_EN: adds bias_in, loaded into the lanes on start.
module sp_psum_accumulator
  import sp_tc_pkg::*;
#(
  parameter int K_STEPS  = 8,
  parameter int FEDP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef PSUM_BIAS_INIT_EN
  input  logic [OUT_W-1:0]      bias_in,
`endif
  output logic                  busy,
  output psum_state_t           dbg_state,
  sp_psum_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(K_STEPS + 1);

  psum_state_t                   state;
  psum_state_t                   state_nxt;
  logic [LANES-1:0][PSUM_W-1:0]  acc;
  logic [CNT_W-1:0]              step_cnt;
  logic [FEDP_LAT-1:0]           inflight;
  logic                          capture;
  logic                          capture_en;
  logic                          issue;
  logic                          tile_start;
  logic                          step_ready_c;
  logic                          out_valid_c;
  logic                          last_step;

  // Tracks issued steps until their FEDP result is due.
  sp_valid_delay #(.DEPTH(FEDP_LAT)) u_valid_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue),
    .taps     (inflight),
    .strobe   (capture)
  );

  assign last_step = (step_cnt == CNT_W'(K_STEPS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; a step is only accepted with nothing in flight.
  always_comb begin
    state_nxt    = state;
    step_ready_c = 1'b0;
    out_valid_c  = 1'b0;
    busy         = 1'b0;
    issue        = 1'b0;
    tile_start   = 1'b0;
    capture_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          tile_start = 1'b1;
          state_nxt  = ACCUM;
        end
      end
      ACCUM: begin
        busy         = 1'b1;
        step_ready_c = (inflight == '0);
        issue        = step_ready_c && bus.step_valid;
        capture_en   = capture;
        if (capture && last_step) state_nxt = OUT;
      end
      OUT: begin
        busy        = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane registers and step counter; the FEDP already added partial_sum, so capture is a plain load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      step_cnt <= '0;
    end else if (tile_start) begin
`ifdef PSUM_BIAS_INIT_EN
      acc      <= bias_in;
`else
      acc      <= '0;
`endif
      step_cnt <= '0;
    end else if (capture_en) begin
      acc[0]   <= bus.result0;
      acc[1]   <= bus.result1;
      acc[2]   <= bus.result2;
      acc[3]   <= bus.result3;
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  assign bus.step_ready   = step_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_data     = acc;
  assign bus.partial_sum0 = acc[0];
  assign bus.partial_sum1 = acc[1];
  assign bus.partial_sum2 = acc[2];
  assign bus.partial_sum3 = acc[3];
  assign dbg_state        = state;

endmodule

// File: tb/tb_sp_psum_accumulator.sv
// Bench for sp_psum_accumulator: instance a (K_STEPS=4, FEDP_LAT=1) and
// instance b (K_STEPS=2, FEDP_LAT=3), each with a 1-cycle registered FEDP model.
module tb_sp_psum_accumulator;
  import sp_tc_pkg::*;

`ifdef PSUM_BIAS_INIT_EN
  localparam logic [15:0] BIAS = 16'd5;
`else
  localparam logic [15:0] BIAS = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic        start_a;
  logic        start_b;
  logic        busy_a;
  logic        busy_b;
  psum_state_t dbg_a;
  psum_state_t dbg_b;
  logic [63:0] bias_word;
  logic [15:0] add_a [4];
  logic [15:0] add_b [4];

  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  int          n_cmp;
  int          n_bad;

  sp_psum_accumulator_if if_a ();
  sp_psum_accumulator_if if_b ();

  sp_psum_accumulator #(.K_STEPS(4), .FEDP_LAT(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
`ifdef PSUM_BIAS_INIT_EN
    .bias_in   (bias_word),
`endif
    .busy      (busy_a),
    .dbg_state (dbg_a),
    .bus       (if_a)
  );

  sp_psum_accumulator #(.K_STEPS(2), .FEDP_LAT(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
`ifdef PSUM_BIAS_INIT_EN
    .bias_in   (bias_word),
`endif
    .busy      (busy_b),
    .dbg_state (dbg_b),
    .bus       (if_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // FEDP models: result = partial_sum + per-lane addend, registered one cycle.
  always @(posedge clk) begin
    if_a.result0 <= if_a.partial_sum0 + add_a[0];
    if_a.result1 <= if_a.partial_sum1 + add_a[1];
    if_a.result2 <= if_a.partial_sum2 + add_a[2];
    if_a.result3 <= if_a.partial_sum3 + add_a[3];
    if_b.result0 <= if_b.partial_sum0 + add_b[0];
    if_b.result1 <= if_b.partial_sum1 + add_b[1];
    if_b.result2 <= if_b.partial_sum2 + add_b[2];
    if_b.result3 <= if_b.partial_sum3 + add_b[3];
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] pack4(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_step_valid(input bit sel_b, input int mode, input int c);
    logic v;
    v = (mode == 0) ? 1'b1 : ((c % 3) != 2);
    if (sel_b) if_b.step_valid = v;
    else       if_a.step_valid = v;
  endtask

  // Pulse start, drive step_valid (mode 0 held, mode 1 two-on/one-off) and wait for
  // out_valid. cyc = edges from start sample to out_valid; trace bit n = step_ready
  // sampled n cycles after the start edge.
  task automatic run_to_valid(input bit sel_b, input int mode, output int cyc,
                              output logic [31:0] trace);
    logic ov;
    trace = '0;
    cyc   = 0;
    if (sel_b) start_b = 1'b1;
    else       start_a = 1'b1;
    set_step_valid(sel_b, mode, 0);
    do begin
      tick();
      cyc++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (cyc < 32) trace[cyc] = sel_b ? if_b.step_ready : if_a.step_ready;
      set_step_valid(sel_b, mode, cyc);
      ov = sel_b ? if_b.out_valid : if_a.out_valid;
    end while (!ov && cyc < 300);
    if (!ov) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_valid_timeout: got 0 expected 1 within 300 cycles");
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && if_a.out_valid && if_a.out_ready) begin
      if (exp_q_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tile_a_unexpected: got %h expected no tile", if_a.out_data);
      end else begin
        check("tile_a", if_a.out_data, exp_q_a.pop_front());
      end
    end
    if (!rst && if_b.out_valid && if_b.out_ready) begin
      if (exp_q_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tile_b_unexpected: got %h expected no tile", if_b.out_data);
      end else begin
        check("tile_b", if_b.out_data, exp_q_b.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          cyc;
    logic [31:0] trace;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bias_word = {4{BIAS}};
    if_a.step_valid = 1'b0;
    if_b.step_valid = 1'b0;
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      add_a[i] = 16'(10 * (i + 1));
      add_b[i] = 16'(10 * (i + 1));
    end
    tick();
    tick();

    // Reset values.
    check("rst_out_valid_a", {63'd0, if_a.out_valid}, 64'd0);
    check("rst_out_data_a", if_a.out_data, 64'd0);
    check("rst_step_ready_a", {63'd0, if_a.step_ready}, 64'd0);
    check("rst_busy_a", {63'd0, busy_a}, 64'd0);
    check("rst_psum_a", {if_a.partial_sum3, if_a.partial_sum2, if_a.partial_sum1,
                         if_a.partial_sum0}, 64'd0);
    check("rst_state_b", 64'(dbg_b), 64'(IDLE));
    check("rst_out_data_b", if_b.out_data, 64'd0);
    rst = 1'b0;
    tick();

    // 1: K=4, L=1, step_valid held -> lanes 40/80/120/160, latency 9.
    exp_q_a.push_back(pack4(16'd40 + BIAS, 16'd80 + BIAS, 16'd120 + BIAS, 16'd160 + BIAS));
    run_to_valid(1'b0, 0, cyc, trace);
    check("t1_latency", 64'(cyc), 64'd9);
    check("t1_ready_trace", 64'(trace), 64'h0000_00AA);
    tick();
    tick();
    check("t1_idle_after", 64'(dbg_a), 64'(IDLE));

    // 2: out_ready held low for 5 cycles; start during OUT and at the handshake ignored.
    if_a.out_ready = 1'b0;
    exp_q_a.push_back(pack4(16'd40 + BIAS, 16'd80 + BIAS, 16'd120 + BIAS, 16'd160 + BIAS));
    run_to_valid(1'b0, 0, cyc, trace);
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_valid", {63'd0, if_a.out_valid}, 64'd1);
      check("t2_hold_data", if_a.out_data,
            pack4(16'd40 + BIAS, 16'd80 + BIAS, 16'd120 + BIAS, 16'd160 + BIAS));
      start_a = (k == 2);
      tick();
    end
    start_a = 1'b1;
    if_a.out_ready = 1'b1;
    tick();
    start_a = 1'b0;
    check("t2_idle_state", 64'(dbg_a), 64'(IDLE));
    check("t2_idle_valid", {63'd0, if_a.out_valid}, 64'd0);
    tick();
    check("t2_start_ignored", {63'd0, busy_a}, 64'd0);

    // 3: step_valid two-on/one-off, pulses while step_ready low; signed addends.
    add_a[0] = 16'd3;
    add_a[1] = 16'hFFF9;
    add_a[2] = 16'd100;
    add_a[3] = 16'd1;
    exp_q_a.push_back(pack4(16'd12 + BIAS, 16'hFFE4 + BIAS, 16'd400 + BIAS, 16'd4 + BIAS));
    run_to_valid(1'b0, 1, cyc, trace);
    tick();
    tick();
    check("t3_idle", {63'd0, busy_a}, 64'd0);

    // 4: K=2, L=3 -> step_ready low 3 cycles after each issue, latency 9.
    exp_q_b.push_back(pack4(16'd20 + BIAS, 16'd40 + BIAS, 16'd60 + BIAS, 16'd80 + BIAS));
    run_to_valid(1'b1, 0, cyc, trace);
    check("t4_latency", 64'(cyc), 64'd9);
    check("t4_ready_trace", 64'(trace), 64'h0000_0022);
    tick();
    tick();

    // 5: reset mid-ACCUM with a step in flight, then a fresh tile.
    for (int i = 0; i < 4; i++) add_a[i] = 16'(10 * (i + 1));
    if_a.step_valid = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("t5_busy", {63'd0, busy_a}, 64'd0);
    check("t5_step_ready", {63'd0, if_a.step_ready}, 64'd0);
    check("t5_psum", {if_a.partial_sum3, if_a.partial_sum2, if_a.partial_sum1,
                      if_a.partial_sum0}, 64'd0);
    check("t5_out_data", if_a.out_data, 64'd0);
    check("t5_state", 64'(dbg_a), 64'(IDLE));
    tick();
    rst = 1'b0;
    tick();
    exp_q_a.push_back(pack4(16'd40 + BIAS, 16'd80 + BIAS, 16'd120 + BIAS, 16'd160 + BIAS));
    run_to_valid(1'b0, 0, cyc, trace);
    check("t5_latency", 64'(cyc), 64'd9);
    tick();
    tick();

    // 6: 16-bit wrap, 0x7FF0 per step over K=2 -> 0xFFE0.
    for (int i = 0; i < 4; i++) add_b[i] = 16'h7FF0;
    exp_q_b.push_back(pack4(16'hFFE0 + BIAS, 16'hFFE0 + BIAS, 16'hFFE0 + BIAS,
                            16'hFFE0 + BIAS));
    run_to_valid(1'b1, 0, cyc, trace);
    tick();
    tick();
    tick();

    check("leftover_a", 64'(exp_q_a.size()), 64'd0);
    check("leftover_b", 64'(exp_q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
